// File: rtl/store_checker_if.sv
// Store-checker bus: core store snoop, trace pop port and verdict flags.
// Latency: none, wiring only.
// Backpressure: none; rd_en is a pop request, stores are never stalled.
interface store_checker_if #(
   parameter int DEPTH = 8
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic          memwrite;
   logic [31:0]   dataadr;
   logic [31:0]   writedata;
   logic [31:0]   pc;
   logic          rd_en;
   logic          rd_valid;
   logic [31:0]   rd_addr;
   logic [31:0]   rd_data;
   logic [31:0]   rd_pc;
   logic [CW-1:0] count;
   logic          overflow;
   logic          done;
   logic          pass;
   logic          fail;
   logic          timeout;
   logic [31:0]   fail_addr;
   logic [31:0]   fail_data;

   // Core/host side.
   modport master (
      output memwrite, dataadr, writedata, pc, rd_en,
      input  rd_valid, rd_addr, rd_data, rd_pc, count, overflow,
      input  done, pass, fail, timeout, fail_addr, fail_data
   );

   // Checker side.
   modport slave (
      input  memwrite, dataadr, writedata, pc, rd_en,
      output rd_valid, rd_addr, rd_data, rd_pc, count, overflow,
      output done, pass, fail, timeout, fail_addr, fail_data
   );
endinterface

// File: rtl/store_checker.sv
// Watches core stores, decides pass/fail in hardware and traces every store into a FIFO.
// Latency: verdict flags 1 cycle after the deciding store; pop data 1 cycle after rd_en.
// Backpressure: none to the core; a full trace FIFO drops the store and sets sticky overflow.
module store_checker #(
   parameter int          DEPTH        = 8,
   parameter logic [31:0] PASS_ADDR    = 32'd84,
   parameter logic [31:0] PASS_DATA    = 32'd7,
   parameter logic [31:0] SCRATCH_ADDR = 32'd80,
   parameter int          TIMEOUT      = 1000
) (
   input logic             clk,
   input logic             reset,
   store_checker_if.slave  bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {RUN, PASS, FAIL} state_t;

   typedef struct packed {
      logic [31:0] adr;
      logic [31:0] dat;
      logic [31:0] pc;
   } entry_t;

   state_t        state_q, state_d;
   logic [TW-1:0] cyc_q, cyc_d;
   logic          latch_store;
   logic          latch_timeout;
   logic          timeout_q;
   logic [31:0]   fail_addr_q;
   logic [31:0]   fail_data_q;

   entry_t        mem [DEPTH];
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q;
   logic          overflow_q;
   logic          rd_valid_q;
   entry_t        rd_q;

   logic          push, pop, push_ok;

   // Only stores seen while still running are traced; a pop needs a stored entry,
   // and a push into a full FIFO survives only if a pop frees a slot that same cycle.
   assign push    = bus.memwrite && (state_q == RUN);
   assign pop     = bus.rd_en && (count_q != '0);
   assign push_ok = push && ((count_q < CW'(DEPTH)) || pop);

   // Verdict next-state: a deciding store takes priority over timeout expiry.
   always_comb begin
      state_d       = state_q;
      cyc_d         = cyc_q;
      latch_store   = 1'b0;
      latch_timeout = 1'b0;
      if (state_q == RUN) begin
         if (bus.memwrite && bus.dataadr == PASS_ADDR && bus.writedata == PASS_DATA) begin
            state_d = PASS;
         end else if (bus.memwrite && bus.dataadr != SCRATCH_ADDR) begin
            state_d     = FAIL;
            latch_store = 1'b1;
         end else if (cyc_q == TW'(TIMEOUT - 1)) begin
            state_d       = FAIL;
            latch_timeout = 1'b1;
         end else begin
            cyc_d = cyc_q + TW'(1);
         end
      end
   end

   // Verdict state, cycle counter and failure details.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= RUN;
         cyc_q       <= '0;
         timeout_q   <= 1'b0;
         fail_addr_q <= '0;
         fail_data_q <= '0;
      end else begin
         state_q <= state_d;
         cyc_q   <= cyc_d;
         if (latch_timeout) begin
            timeout_q <= 1'b1;
         end
         if (latch_store) begin
            fail_addr_q <= bus.dataadr;
            fail_data_q <= bus.writedata;
         end
      end
   end

   // Trace storage; contents need no reset because the pointers gate every read.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr_q] <= '{adr: bus.dataadr, dat: bus.writedata, pc: bus.pc};
      end
   end

   // FIFO pointers, occupancy, overflow flag and registered pop output.
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_q       <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr_q <= wr_ptr_q + PW'(1);
         end
         if (push && !push_ok) begin
            overflow_q <= 1'b1;
         end
         rd_valid_q <= pop;
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PW'(1);
            rd_q     <= mem[rd_ptr_q];
         end
         case ({push_ok, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   assign bus.rd_valid  = rd_valid_q;
   assign bus.rd_addr   = rd_q.adr;
   assign bus.rd_data   = rd_q.dat;
   assign bus.rd_pc     = rd_q.pc;
   assign bus.count     = count_q;
   assign bus.overflow  = overflow_q;
   assign bus.pass      = (state_q == PASS);
   assign bus.fail      = (state_q == FAIL);
   assign bus.done      = (state_q == PASS) || (state_q == FAIL);
   assign bus.timeout   = timeout_q;
   assign bus.fail_addr = fail_addr_q;
   assign bus.fail_data = fail_data_q;
endmodule

// File: tb/tb_store_checker.sv
// Randomized and directed bench for store_checker with a queue-based reference model.
// Latency: model state is updated right after each rising edge, compared at the falling edge.
// Backpressure: popped entries go to a scoreboard queue, drained whenever rd_valid is seen.
module tb_store_checker;
   localparam int DEPTH = 8;
   localparam int TMO   = 24;

   typedef struct {
      logic [31:0] a;
      logic [31:0] d;
      logic [31:0] p;
   } ent_t;

   logic clk = 1'b0;
   logic reset;

   store_checker_if #(.DEPTH(DEPTH)) bus ();

   store_checker #(
      .DEPTH(DEPTH), .PASS_ADDR(32'd84), .PASS_DATA(32'd7),
      .SCRATCH_ADDR(32'd80), .TIMEOUT(TMO)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   always #5 clk = ~clk;

   // Reference model: 0 = running, 1 = passed, 2 = failed.
   int          m_state;
   int          m_cyc;
   ent_t        m_fifo[$];
   ent_t        exp_q[$];
   logic        m_ovf, m_to, m_rdv;
   logic [31:0] m_fa, m_fd, m_rda, m_rdd, m_rdp;

   int  n_checks = 0;
   int  n_errors = 0;
   bit  mon_en   = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_edge(input logic mw, input logic [31:0] a, d, p,
                             input logic re, input logic rst);
      ent_t e;
      bit   decided;
      if (!rst) begin
         m_state = 0; m_cyc = 0; m_fifo.delete();
         m_ovf = 0; m_to = 0; m_rdv = 0;
         m_fa = 0; m_fd = 0; m_rda = 0; m_rdd = 0; m_rdp = 0;
      end else begin
         if (re && m_fifo.size() > 0) begin
            e = m_fifo.pop_front();
            exp_q.push_back(e);
            m_rdv = 1; m_rda = e.a; m_rdd = e.d; m_rdp = e.p;
         end else begin
            m_rdv = 0;
         end
         if (mw && m_state == 0) begin
            if (m_fifo.size() < DEPTH) m_fifo.push_back('{a, d, p});
            else m_ovf = 1;
         end
         if (m_state == 0) begin
            decided = 0;
            if (mw && a == 84 && d == 7) begin
               m_state = 1; decided = 1;
            end else if (mw && a != 80) begin
               m_state = 2; m_fa = a; m_fd = d; decided = 1;
            end
            if (!decided) begin
               if (m_cyc == TMO - 1) begin
                  m_state = 2; m_to = 1;
               end else begin
                  m_cyc++;
               end
            end
         end
      end
   endtask

   task automatic step(input logic mw, input logic [31:0] a, d, input logic re, input logic rst);
      logic [31:0] p;
      p = $urandom;
      bus.memwrite = mw; bus.dataadr = a; bus.writedata = d; bus.pc = p;
      bus.rd_en = re; reset = rst;
      @(posedge clk);
      model_edge(mw, a, d, p, re, rst);
      #1;
   endtask

   task automatic store(input logic [31:0] a, d);
      step(1'b1, a, d, 1'b0, 1'b1);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, $urandom, $urandom, 1'b0, 1'b1);
   endtask

   task automatic pop(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 32'd0, 32'd0, 1'b1, 1'b1);
   endtask

   task automatic rst_cycle();
      step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
   endtask

   // Monitor: status compared every cycle; popped entries checked against the scoreboard.
   initial begin
      ent_t e;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            check("count",     32'(bus.count), 32'(m_fifo.size()));
            check("overflow",  32'(bus.overflow), 32'(m_ovf));
            check("pass",      32'(bus.pass), 32'(m_state == 1));
            check("fail",      32'(bus.fail), 32'(m_state == 2));
            check("done",      32'(bus.done), 32'(m_state != 0));
            check("timeout",   32'(bus.timeout), 32'(m_to));
            check("fail_addr", bus.fail_addr, m_fa);
            check("fail_data", bus.fail_data, m_fd);
            check("rd_valid",  32'(bus.rd_valid), 32'(m_rdv));
            check("rd_addr_hold", bus.rd_addr, m_rda);
            if (bus.rd_valid === 1'b1) begin
               if (exp_q.size() == 0) begin
                  n_checks++; n_errors++;
                  $display("FAIL sb_underflow: rd_valid with no expected entry at %0t", $time);
               end else begin
                  e = exp_q.pop_front();
                  check("sb_addr", bus.rd_addr, e.a);
                  check("sb_data", bus.rd_data, e.d);
                  check("sb_pc",   bus.rd_pc,   e.p);
               end
            end
         end
      end
   end

   initial begin
      bit mw, re, rst;
      int r;
      logic [31:0] a, d;
      bus.memwrite = 0; bus.dataadr = 0; bus.writedata = 0; bus.pc = 0; bus.rd_en = 0;
      reset = 0;
      rst_cycle();
      mon_en = 1'b1;
      rst_cycle();
      idle(1);

      // Nominal pass, then drain with one extra pop on empty.
      store(80, 3); store(80, 5); store(84, 7);
      idle(1); pop(4); idle(1);

      // Wrong data at the pass address; later stores are ignored.
      rst_cycle(); store(84, 6); store(84, 7); idle(2); pop(2);

      // Bad address after a scratch store; post-verdict store not traced.
      rst_cycle(); store(80, 1); store(88, 9); store(80, 2); idle(1); pop(3);

      // Overflow: ten scratch stores into an eight-deep FIFO.
      rst_cycle();
      for (int i = 0; i < 10; i++) store(80, i);
      pop(9); idle(1);

      // Push and pop together while full, then while empty.
      rst_cycle();
      for (int i = 0; i < DEPTH; i++) store(80, 100 + i);
      step(1'b1, 80, 200, 1'b1, 1'b1);
      step(1'b1, 80, 201, 1'b1, 1'b1);
      pop(DEPTH + 1);
      step(1'b1, 80, 300, 1'b1, 1'b1);
      pop(2);

      // Timeout with no stores.
      rst_cycle(); idle(TMO + 3);

      // Passing store exactly on the expiry edge.
      rst_cycle(); idle(TMO - 1); store(84, 7); idle(2);

      // Scratch store on the expiry edge still times out.
      rst_cycle(); idle(TMO - 1); store(80, 1); idle(1); pop(1);

      // Mid-run reset after three traced stores, then a nominal run.
      rst_cycle(); store(80, 11); store(80, 12); store(80, 13);
      rst_cycle();
      check("rst_rd_data", bus.rd_data, 32'd0);
      check("rst_rd_pc",   bus.rd_pc,   32'd0);
      store(80, 3); store(80, 5); store(84, 7); pop(3); idle(1);

      // Randomized runs.
      for (int it = 0; it < 8; it++) begin
         rst_cycle();
         for (int c = 0; c < 40; c++) begin
            r  = $urandom_range(0, 9);
            a  = (r <= 6) ? 32'd80 : (r == 7) ? 32'd84 : (r == 8) ? 32'd88 : ($urandom & 32'hFC);
            d  = $urandom_range(0, 7);
            mw = ($urandom_range(0, 1) == 1);
            re = ($urandom_range(0, 2) == 0);
            rst = ($urandom_range(0, 59) != 0);
            step(mw, a, d, re, rst);
         end
         pop(DEPTH + 1);
      end

      idle(2);
      check("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
